// File: rtl/mips_isa_pkg.sv
// MIPS opcode/funct constants, the decoded-instruction record and the
// combinational field decoder shared by the decode stage.
package mips_isa_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] OP_LWU   = 6'b100111;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_JALR  = 6'b001001;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sa;
    logic [15:0] imm;
    logic [25:0] addr_offset;
    logic        pc_modify;
    logic        branch;
    logic        addr_type;
    logic [4:0]  link_reg;
    logic [4:0]  addr_reg;
    logic        exc_unknown;
  } dec_fields_t;

  function automatic dec_fields_t decode_instr(input logic [31:0] instr,
                                               input logic [4:0]  link_reg);
    dec_fields_t d;
    d        = '0;
    d.opcode = instr[31:26];
    case (instr[31:26])
      OP_RTYPE: begin
        d.rs = instr[25:21];
        if (instr[5:0] == FN_JR || instr[5:0] == FN_JALR) begin
          // Register jumps report the target register, not the funct code
          d.addr_reg  = instr[25:21];
          d.pc_modify = 1'b1;
          if (instr[5:0] == FN_JALR) begin
            d.rd       = instr[15:11];
            d.link_reg = instr[15:11];
          end
        end else begin
          d.funct = instr[5:0];
          d.rt    = instr[20:16];
          d.rd    = instr[15:11];
          d.sa    = instr[10:6];
        end
      end
      OP_J, OP_JAL: begin
        d.addr_offset = instr[25:0];
        d.pc_modify   = 1'b1;
        d.addr_type   = 1'b1;
        if (instr[31:26] == OP_JAL) d.link_reg = link_reg;
      end
      OP_BEQ, OP_BNE: begin
        d.rs        = instr[25:21];
        d.rt        = instr[20:16];
        d.imm       = instr[15:0];
        d.pc_modify = 1'b1;
        d.branch    = 1'b1;
        d.addr_type = 1'b1;
      end
      6'b001000, 6'b001001, 6'b001010, 6'b001011,
      6'b001100, 6'b001101, 6'b001110, 6'b001111,
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LWU,
      OP_SB, OP_SH, OP_SW: begin
        d.rs  = instr[25:21];
        d.rt  = instr[20:16];
        d.imm = instr[15:0];
      end
      default: d.exc_unknown = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Power-of-two circular instruction buffer with occupancy count and flush.
module instr_fifo
  import mips_isa_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [DATA_W-1:0]          din_i,
  input  logic                       pop_i,
  output logic [DATA_W-1:0]          dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  // Pointers wrap naturally because DEPTH is a power of two
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/instr_decode_stage.sv
// Instruction decode stage: buffers fetched words in instr_fifo, decodes the
// head combinationally and registers the decoded fields for the next stage.
module instr_decode_stage
  import mips_isa_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int LINK_REG = 31
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [31:0]                i_instr,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic                       i_stall,
  input  logic                       i_flush,
  output logic                       o_valid,
  output logic [5:0]                 o_opcode,
  output logic [5:0]                 o_funct,
  output logic [4:0]                 o_rs,
  output logic [4:0]                 o_rt,
  output logic [4:0]                 o_rd,
  output logic [4:0]                 o_sa,
  output logic [15:0]                o_imm,
  output logic [25:0]                o_addr_offset,
  output logic                       o_flg_pc_modify,
  output logic                       o_flg_branch,
  output logic                       o_flg_addr_type,
  output logic [4:0]                 o_link_reg,
  output logic [4:0]                 o_addr_reg,
  output logic                       o_exc_unknown,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  logic        full, empty, push, load;
  logic [31:0] head;
  dec_fields_t head_dec, dec_q, dec_d;
  logic        valid_q, valid_d;

  // Ready is held low while reset is asserted so nothing is offered early
  assign o_ready  = i_rst_n && !full;
  assign push     = i_valid && o_ready && !i_flush;
  assign load     = !empty && (!valid_q || !i_stall) && !i_flush;
  assign head_dec = decode_instr(head, 5'(LINK_REG));

  instr_fifo #(.DEPTH(DEPTH), .DATA_W(32)) u_fifo (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .flush_i (i_flush),
    .push_i  (push),
    .din_i   (i_instr),
    .pop_i   (load),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (o_count)
  );

  always_comb begin
    valid_d = valid_q;
    dec_d   = dec_q;
    if (i_flush) begin
      valid_d = 1'b0;
      dec_d   = '0;
    end else if (load) begin
      valid_d = 1'b1;
      dec_d   = head_dec;
    end else if (valid_q && !i_stall) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      dec_q   <= '0;
    end else begin
      valid_q <= valid_d;
      dec_q   <= dec_d;
    end
  end

  assign o_valid         = valid_q;
  assign o_opcode        = dec_q.opcode;
  assign o_funct         = dec_q.funct;
  assign o_rs            = dec_q.rs;
  assign o_rt            = dec_q.rt;
  assign o_rd            = dec_q.rd;
  assign o_sa            = dec_q.sa;
  assign o_imm           = dec_q.imm;
  assign o_addr_offset   = dec_q.addr_offset;
  assign o_flg_pc_modify = dec_q.pc_modify;
  assign o_flg_branch    = dec_q.branch;
  assign o_flg_addr_type = dec_q.addr_type;
  assign o_link_reg      = dec_q.link_reg;
  assign o_addr_reg      = dec_q.addr_reg;
  assign o_exc_unknown   = dec_q.exc_unknown;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed bench for instr_decode_stage with DEPTH=4, LINK_REG=31.
module tb_instr_decode_stage;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [31:0] i_instr = '0;
  logic        i_valid = 1'b0;
  logic        i_stall = 1'b0;
  logic        i_flush = 1'b0;
  logic        o_ready, o_valid;
  logic [5:0]  o_opcode, o_funct;
  logic [4:0]  o_rs, o_rt, o_rd, o_sa, o_link_reg, o_addr_reg;
  logic [15:0] o_imm;
  logic [25:0] o_addr_offset;
  logic        o_flg_pc_modify, o_flg_branch, o_flg_addr_type, o_exc_unknown;
  logic [2:0]  o_count;

  int tests = 0;
  int fails = 0;

  instr_decode_stage #(.DEPTH(4), .LINK_REG(31)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_instr(i_instr), .i_valid(i_valid),
    .o_ready(o_ready), .i_stall(i_stall), .i_flush(i_flush), .o_valid(o_valid),
    .o_opcode(o_opcode), .o_funct(o_funct), .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd),
    .o_sa(o_sa), .o_imm(o_imm), .o_addr_offset(o_addr_offset),
    .o_flg_pc_modify(o_flg_pc_modify), .o_flg_branch(o_flg_branch),
    .o_flg_addr_type(o_flg_addr_type), .o_link_reg(o_link_reg),
    .o_addr_reg(o_addr_reg), .o_exc_unknown(o_exc_unknown), .o_count(o_count)
  );

  always #5 i_clk = ~i_clk;

  task automatic step;
    @(posedge i_clk);
    #1;
  endtask

  task automatic push_and_load(input logic [31:0] w);
    i_instr = w; i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    step();
  endtask

  task automatic drain;
    i_valid = 1'b0; i_stall = 1'b0; i_flush = 1'b0;
    repeat (6) step();
  endtask

  task automatic test_reset;
    repeat (2) step();
    tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %0h exp 0", o_valid); end
    tests++; if (o_count !== 3'd0) begin fails++; $display("FAIL rst_count got %0d exp 0", o_count); end
    tests++; if (o_ready !== 1'b0) begin fails++; $display("FAIL rst_ready got %0h exp 0", o_ready); end
    tests++; if (o_opcode !== 6'h0 || o_exc_unknown !== 1'b0) begin fails++; $display("FAIL rst_fields got op=%0h exc=%0h exp 0", o_opcode, o_exc_unknown); end
    i_rst_n = 1'b1;
    #1;
    tests++; if (o_ready !== 1'b1) begin fails++; $display("FAIL rst_release_ready got %0h exp 1", o_ready); end
  endtask

  task automatic test_add;
    i_instr = 32'h00221820; i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    tests++; if (o_valid !== 1'b0 || o_count !== 3'd1) begin fails++; $display("FAIL add_lat1 got valid=%0h cnt=%0d exp 0/1", o_valid, o_count); end
    step();
    tests++; if (o_valid !== 1'b1) begin fails++; $display("FAIL add_valid got %0h exp 1", o_valid); end
    tests++; if ({o_rs, o_rt, o_rd, o_sa} !== {5'd1, 5'd2, 5'd3, 5'd0}) begin fails++; $display("FAIL add_regs got rs=%0d rt=%0d rd=%0d sa=%0d exp 1 2 3 0", o_rs, o_rt, o_rd, o_sa); end
    tests++; if (o_funct !== 6'h20 || o_opcode !== 6'h00) begin fails++; $display("FAIL add_funct got %0h/%0h exp 20/0", o_funct, o_opcode); end
    tests++; if ({o_flg_pc_modify, o_flg_branch, o_flg_addr_type, o_exc_unknown} !== 4'b0000 || o_link_reg !== 5'd0 || o_imm !== 16'd0) begin fails++; $display("FAIL add_flags got %b link=%0d imm=%0h exp 0", {o_flg_pc_modify, o_flg_branch, o_flg_addr_type, o_exc_unknown}, o_link_reg, o_imm); end
    step();
    tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL add_consumed got %0h exp 0", o_valid); end
  endtask

  task automatic test_jalr_jr;
    push_and_load(32'h0080F809);
    tests++; if ({o_flg_pc_modify, o_flg_branch, o_flg_addr_type} !== 3'b100) begin fails++; $display("FAIL jalr_flags got %b exp 100", {o_flg_pc_modify, o_flg_branch, o_flg_addr_type}); end
    tests++; if (o_link_reg !== 5'd31 || o_addr_reg !== 5'd4 || o_rs !== 5'd4 || o_rd !== 5'd31) begin fails++; $display("FAIL jalr_regs got link=%0d addr=%0d rs=%0d rd=%0d exp 31 4 4 31", o_link_reg, o_addr_reg, o_rs, o_rd); end
    tests++; if (o_funct !== 6'h0 || o_valid !== 1'b1) begin fails++; $display("FAIL jalr_funct got %0h v=%0h exp 0 v=1", o_funct, o_valid); end
    push_and_load(32'h03E00008);
    tests++; if (o_rs !== 5'd31 || o_addr_reg !== 5'd31 || o_funct !== 6'h0 || o_link_reg !== 5'd0 || o_rd !== 5'd0) begin fails++; $display("FAIL jr_fields got rs=%0d addr=%0d fn=%0h link=%0d rd=%0d exp 31 31 0 0 0", o_rs, o_addr_reg, o_funct, o_link_reg, o_rd); end
    tests++; if ({o_flg_pc_modify, o_flg_branch, o_flg_addr_type} !== 3'b100) begin fails++; $display("FAIL jr_flags got %b exp 100", {o_flg_pc_modify, o_flg_branch, o_flg_addr_type}); end
    drain();
  endtask

  task automatic test_back_to_back;
    i_stall = 1'b1;
    for (int k = 0; k < 6; k++) begin
      i_instr = {6'd0, 5'd1, 5'd2, 5'(10 + k), 5'd0, 6'h20};
      i_valid = 1'b1;
      step();
    end
    i_valid = 1'b0;
    tests++; if (o_count !== 3'd4) begin fails++; $display("FAIL b2b_count got %0d exp 4", o_count); end
    tests++; if (o_ready !== 1'b0) begin fails++; $display("FAIL b2b_ready got %0h exp 0", o_ready); end
    step();
    tests++; if (o_valid !== 1'b1 || o_rd !== 5'd10) begin fails++; $display("FAIL b2b_hold got v=%0h rd=%0d exp 1 10", o_valid, o_rd); end
    i_stall = 1'b0;
    for (int k = 1; k < 5; k++) begin
      step();
      tests++; if (o_valid !== 1'b1 || o_rd !== 5'(10 + k)) begin fails++; $display("FAIL b2b_order%0d got v=%0h rd=%0d exp 1 %0d", k, o_valid, o_rd, 10 + k); end
    end
    step();
    tests++; if (o_valid !== 1'b0 || o_count !== 3'd0) begin fails++; $display("FAIL b2b_end got v=%0h cnt=%0d exp 0 0", o_valid, o_count); end
    drain();
  endtask

  task automatic test_branch_jal;
    i_instr = 32'h10220003; i_valid = 1'b1;
    step();
    i_instr = 32'h0C000010;
    step();
    i_valid = 1'b0;
    tests++; if (o_opcode !== 6'h04 || o_rs !== 5'd1 || o_rt !== 5'd2 || o_imm !== 16'd3) begin fails++; $display("FAIL beq_fields got op=%0h rs=%0d rt=%0d imm=%0h exp 4 1 2 3", o_opcode, o_rs, o_rt, o_imm); end
    tests++; if ({o_flg_pc_modify, o_flg_branch, o_flg_addr_type} !== 3'b111) begin fails++; $display("FAIL beq_flags got %b exp 111", {o_flg_pc_modify, o_flg_branch, o_flg_addr_type}); end
    step();
    tests++; if (o_addr_offset !== 26'h10 || o_link_reg !== 5'd31 || o_opcode !== 6'h03) begin fails++; $display("FAIL jal_fields got off=%0h link=%0d op=%0h exp 10 31 3", o_addr_offset, o_link_reg, o_opcode); end
    tests++; if ({o_flg_pc_modify, o_flg_branch, o_flg_addr_type} !== 3'b101 || o_imm !== 16'd0) begin fails++; $display("FAIL jal_flags got %b imm=%0h exp 101 0", {o_flg_pc_modify, o_flg_branch, o_flg_addr_type}, o_imm); end
    push_and_load(32'h08000123);
    tests++; if (o_addr_offset !== 26'h123 || o_link_reg !== 5'd0 || o_flg_addr_type !== 1'b1) begin fails++; $display("FAIL j_fields got off=%0h link=%0d at=%0h exp 123 0 1", o_addr_offset, o_link_reg, o_flg_addr_type); end
    push_and_load(32'h8C450004);
    tests++; if (o_rs !== 5'd2 || o_rt !== 5'd5 || o_imm !== 16'd4 || o_flg_pc_modify !== 1'b0 || o_rd !== 5'd0) begin fails++; $display("FAIL lw_fields got rs=%0d rt=%0d imm=%0h pcm=%0h rd=%0d exp 2 5 4 0 0", o_rs, o_rt, o_imm, o_flg_pc_modify, o_rd); end
    drain();
  endtask

  task automatic test_flush;
    i_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      i_instr = {6'd0, 5'd1, 5'd2, 5'(20 + k), 5'd0, 6'h20};
      i_valid = 1'b1;
      step();
    end
    tests++; if (o_count !== 3'd2 || o_valid !== 1'b1) begin fails++; $display("FAIL flush_pre got cnt=%0d v=%0h exp 2 1", o_count, o_valid); end
    i_instr = {6'd0, 5'd1, 5'd2, 5'd25, 5'd0, 6'h20};
    i_flush = 1'b1;
    step();
    i_flush = 1'b0; i_valid = 1'b0;
    tests++; if (o_valid !== 1'b0 || o_count !== 3'd0 || o_rd !== 5'd0 || o_funct !== 6'd0) begin fails++; $display("FAIL flush_clear got v=%0h cnt=%0d rd=%0d fn=%0h exp 0 0 0 0", o_valid, o_count, o_rd, o_funct); end
    i_stall = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL flush_ghost%0d got v=%0h rd=%0d exp v=0", k, o_valid, o_rd); end
    end
  endtask

  task automatic test_unknown_and_reset;
    push_and_load(32'hFC000000);
    tests++; if (o_exc_unknown !== 1'b1 || o_valid !== 1'b1 || o_opcode !== 6'h3F) begin fails++; $display("FAIL unk_flag got exc=%0h v=%0h op=%0h exp 1 1 3f", o_exc_unknown, o_valid, o_opcode); end
    tests++; if ({o_rs, o_rt, o_rd, o_sa, o_imm, o_addr_offset, o_flg_pc_modify, o_flg_branch, o_flg_addr_type} !== '0) begin fails++; $display("FAIL unk_zero got rs=%0d rt=%0d imm=%0h off=%0h exp 0", o_rs, o_rt, o_imm, o_addr_offset); end
    i_stall = 1'b1;
    i_instr = 32'h00221820; i_valid = 1'b1;
    step(); step();
    i_valid = 1'b0;
    #2;
    i_rst_n = 1'b0;
    #1;
    tests++; if (o_valid !== 1'b0 || o_exc_unknown !== 1'b0 || o_opcode !== 6'h0 || o_count !== 3'd0 || o_ready !== 1'b0) begin fails++; $display("FAIL midrst got v=%0h exc=%0h op=%0h cnt=%0d rdy=%0h exp all 0", o_valid, o_exc_unknown, o_opcode, o_count, o_ready); end
    i_stall = 1'b0;
    step();
    i_rst_n = 1'b1;
    i_instr = 32'h0080F809; i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    tests++; if (o_count !== 3'd1 || o_valid !== 1'b0) begin fails++; $display("FAIL post_rst_write got cnt=%0d v=%0h exp 1 0", o_count, o_valid); end
    step();
    tests++; if (o_valid !== 1'b1 || o_addr_reg !== 5'd4) begin fails++; $display("FAIL post_rst_load got v=%0h addr=%0d exp 1 4", o_valid, o_addr_reg); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_jalr_jr();
    test_back_to_back();
    test_branch_jal();
    test_flush();
    test_unknown_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
